// File: rtl/reg_wr_demux.sv
// Write-side decode path of the register file: a 2-entry request FIFO that
// drains one {addr, data} entry per cycle into a one-hot write enable.
// Writes to register 0 are accepted, discarded and counted.
module reg_wr_demux (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_addr,
    input  logic [31:0] in_data,
    input  logic        stall,
    output logic [31:0] we,
    output logic [31:0] wd,
    output logic [4:0]  wr_addr,
    output logic [1:0]  pending,
    output logic [7:0]  drop_cnt
);

    // Encoding equals the buffered entry count, so pending is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  slot_addr [2];
    logic [31:0] slot_data [2];
    logic        wr_ptr;
    logic        rd_ptr;

    logic        accept;
    logic        push;
    logic        drop;
    logic        pop;
    logic [4:0]  head_addr;
    logic [31:0] head_data;

    // Ready comes from the count register alone; no path from stall or in_valid.
    assign in_ready = (state != FULL);
    assign pending  = state;

    // Handshake and drain decode for the current cycle.
    always_comb begin
        // NOTE: every signal gets a default first so always_comb cannot infer a latch.
        accept    = 1'b0;
        push      = 1'b0;
        drop      = 1'b0;
        pop       = 1'b0;
        head_addr = slot_addr[rd_ptr];
        head_data = slot_data[rd_ptr];
        accept    = in_valid && in_ready;
        push      = accept && (in_addr != 5'd0);
        drop      = accept && (in_addr == 5'd0);
        // Pop looks at the registered count, so a push into EMPTY drains next edge.
        pop       = (state != EMPTY) && !stall;
    end

    // Entry storage; validity is tracked by state, so the slots need no reset.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays are left unreset; invalidation happens through the count.
        if (!reset && push) begin
            slot_addr[wr_ptr] <= in_addr;
            slot_data[wr_ptr] <= in_data;
        end
    end

    // FIFO state, pointers, registered write port and drop counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state    <= EMPTY;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            we       <= 32'd0;
            wd       <= 32'd0;
            wr_addr  <= 5'd0;
            drop_cnt <= 8'd0;
        end else begin
            case (state)
                EMPTY:   if (push) state <= ONE;
                ONE: begin
                    if (push && !pop)      state <= FULL;
                    else if (!push && pop) state <= EMPTY;
                end
                FULL:    if (pop) state <= ONE;
                default: state <= EMPTY;
            endcase

            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;

            // Register 0 is never enqueued, so we[0] cannot be driven.
            if (pop) begin
                we      <= 32'd1 << head_addr;
                wd      <= head_data;
                wr_addr <= head_addr;
            end else begin
                we      <= 32'd0;
            end

            if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule
